cr_cddip_support_mc: RTL and testbench
======================================

# cr_cddip_support_mc

Multi-channel successor to the CDDIP support core. Tracks per-channel in-flight command queue entries (CQE received vs. exited) across `N_CH` engine channels, and derives a debounced engine-idle indication and a threshold-based output-FIFO halt. It also aggregates `N_INT_SRC` interrupt sources into a single maskable, sticky engine interrupt. It sits between the ISF/OSF stream front-ends and the support regfile, which reads its status vectors.

## Interface
Parameters:
- `N_CH`, 4, number of independent command channels (1..16)
- `CNT_W`, 16, in-flight counter width per channel
- `IDLE_HOLD`, 8, consecutive quiet cycles required before `idle` asserts (≥1)
- `N_INT_SRC`, 8, number of interrupt source bits

Ports:
- `clk`  in  1  single clock domain
- `rst_n`  in  1  asynchronous, active-low reset
- `cqe_rx`  in  N_CH  per-channel one-cycle pulse: CQE accepted by ISF
- `cqe_exit`  in  N_CH  per-channel one-cycle pulse: CQE retired by OSF
- `halt_en`  in  1  enables halt generation
- `halt_thresh`  in  CNT_W  shared in-flight threshold; 0 disables halt
- `int_src`  in  N_INT_SRC  level/pulse interrupt sources
- `int_mask`  in  N_INT_SRC  1 = source masked from `int_out`
- `int_clr`  in  N_INT_SRC  W1C pulse clearing `int_stat` bits
- `err_clr`  in  1  pulse clearing all error sticky bits
- `inflight`  out  N_CH*CNT_W  registered per-channel counts; channel c at bits [c*CNT_W +: CNT_W]
- `ovf_err`  out  N_CH  sticky: rx while counter saturated
- `unf_err`  out  N_CH  sticky: exit while counter zero
- `int_stat`  out  N_INT_SRC  sticky interrupt status
- `int_out`  out  1  aggregated engine interrupt
- `idle`  out  1  engine idle
- `halt`  out  1  halt request to OSF

## Operation
- Reset values: `inflight`=0, `ovf_err`/`unf_err`=0, `int_stat`=0, `int_out`=0, `idle`=0, `halt`=0, idle FSM in BUSY, quiet counter 0.
- Per-channel counter:
  - rx only → +1.
  - exit only → −1.
  - rx and exit in the same cycle → unchanged, with no error even at 0 or at max.
  - rx only at 2^CNT_W−1 → holds at max and sets `ovf_err[c]`.
  - exit only at 0 → holds at 0 and sets `unf_err[c]`.
- Error bits: a set in the same cycle as `err_clr` wins.
- Quiet cycle: every `inflight` counter is 0 and `cqe_rx`/`cqe_exit` are all 0.
- Idle FSM:
  - BUSY → DRAIN on a quiet cycle; the quiet counter loads 1.
  - DRAIN: each further quiet cycle increments the quiet counter. On reaching `IDLE_HOLD` → IDLE.
  - DRAIN: any non-quiet cycle → BUSY and the counter clears.
  - IDLE: `idle`=1. Any rx or exit pulse on any channel → BUSY and `idle`=0.
  - `IDLE_HOLD`=1: BUSY goes directly to IDLE on the first quiet cycle.
- Halt: `halt` = `halt_en` & (`halt_thresh`≠0) & (any channel next-state count ≥ `halt_thresh`). Recomputed every cycle with no hysteresis.
- Interrupts:
  - `int_stat[i]` sets on `int_src[i]`=1 and clears on `int_clr[i]`; a set wins over a clear in the same cycle.
  - `int_out` = |(`int_stat` & ~`int_mask`) | (|`ovf_err`) | (|`unf_err`). Errors cannot be masked.

## Timing
- `inflight`, error bits and `halt` update on the same edge that samples the rx/exit pulse (1-cycle latency).
- `int_stat` updates on the edge that samples `int_src`. `int_out` is registered from the current `int_stat`/error state, so it asserts 2 edges after the source and deasserts 2 edges after `int_clr`. Mask changes take effect 1 edge later.
- `idle` rises on the edge ending quiet cycle `IDLE_HOLD` and falls on the edge that samples the first rx/exit pulse.
- An `rst_n` assertion mid-operation clears all state immediately, regardless of clock. No pulses are remembered across reset.

## Test plan
- Reset, N_CH=4, IDLE_HOLD=8, no traffic → `idle` rises on the 8th edge after reset release; all other outputs stay 0.
- ch0: 5 rx pulses, then 5 exit pulses → `inflight[0]` steps 1..5..0; `idle` low throughout, high 8 cycles after the last exit; no errors.
- ch2: rx and exit together for 10 cycles with count 0 → count stays 0, `unf_err`=0. Then a lone exit → `unf_err[2]`=1 and `int_out`=1 two edges later. `err_clr` clears both.
- CNT_W=4, ch1 given 16 rx pulses → count saturates at 15 on the 15th pulse; `ovf_err[1]` is set on the 16th.
- `halt_en`=1, `halt_thresh`=3, ch3: 3 rx → `halt`=1 on the 3rd rx edge. 1 exit → `halt`=0 on that edge. Repeat with `halt_thresh`=0 → `halt` never asserts.
- `int_src[5]` pulsed with `int_mask[5]`=1 → `int_stat[5]`=1, `int_out`=0. Unmask → `int_out`=1 next edge. `int_clr[5]` asserted coincident with a new `int_src[5]` → bit stays 1.

Source files
------------

// File: rtl/cr_cddip_support_mc.sv
// CDDIP multi-channel support core: per-channel in-flight CQE counters with
// sticky over/underflow errors, debounced engine idle, threshold halt and a
// maskable sticky interrupt aggregator.

// Per-channel in-flight counter with saturating limits and sticky errors.
module cr_cddip_support_mc_ch #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx,
    input  logic             ex,
    input  logic             err_clr,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] cnt_next,
    output logic             ovf,
    output logic             unf
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic ovf_set, unf_set;

    // Next count; simultaneous rx/exit cancel with no error.
    always_comb begin
        cnt_next = cnt;
        ovf_set  = 1'b0;
        unf_set  = 1'b0;
        if (rx && !ex) begin
            if (cnt == CNT_MAX) ovf_set = 1'b1;
            else                cnt_next = cnt + 1'b1;
        end else if (ex && !rx) begin
            if (cnt == '0) unf_set = 1'b1;
            else           cnt_next = cnt - 1'b1;
        end
    end

    // Count and sticky error state; a new error beats err_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            cnt <= cnt_next;
            ovf <= ovf_set | (ovf & ~err_clr);
            unf <= unf_set | (unf & ~err_clr);
        end
    end
endmodule

module cr_cddip_support_mc #(
    parameter int N_CH      = 4,
    parameter int CNT_W     = 16,
    parameter int IDLE_HOLD = 8,
    parameter int N_INT_SRC = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH-1:0]       cqe_rx,
    input  logic [N_CH-1:0]       cqe_exit,
    input  logic                  halt_en,
    input  logic [CNT_W-1:0]      halt_thresh,
    input  logic [N_INT_SRC-1:0]  int_src,
    input  logic [N_INT_SRC-1:0]  int_mask,
    input  logic [N_INT_SRC-1:0]  int_clr,
    input  logic                  err_clr,
    output logic [N_CH*CNT_W-1:0] inflight,
    output logic [N_CH-1:0]       ovf_err,
    output logic [N_CH-1:0]       unf_err,
    output logic [N_INT_SRC-1:0]  int_stat,
    output logic                  int_out,
    output logic                  idle,
    output logic                  halt
);
    localparam int QW = $clog2(IDLE_HOLD + 1);

    typedef enum logic [1:0] {BUSY, DRAIN, IDLE} state_t;

    logic [N_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [N_CH-1:0]            ch_zero, ch_hit;
    logic                       any_pulse, quiet;
    state_t                     state_q, state_d;
    logic [QW-1:0]              qcnt_q, qcnt_d;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        cr_cddip_support_mc_ch #(.CNT_W(CNT_W)) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .rx       (cqe_rx[c]),
            .ex       (cqe_exit[c]),
            .err_clr  (err_clr),
            .cnt      (cnt_q[c]),
            .cnt_next (cnt_d[c]),
            .ovf      (ovf_err[c]),
            .unf      (unf_err[c])
        );
        assign ch_zero[c] = (cnt_q[c] == '0);
        assign ch_hit[c]  = (cnt_d[c] >= halt_thresh);
    end

    assign inflight  = cnt_q;
    assign any_pulse = (|cqe_rx) | (|cqe_exit);
    assign quiet     = (&ch_zero) & ~any_pulse;
    assign idle      = (state_q == IDLE);

    // Idle FSM state and quiet-cycle counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BUSY;
            qcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            qcnt_q  <= qcnt_d;
        end
    end

    // Idle FSM: IDLE_HOLD consecutive quiet cycles reach IDLE; a pulse leaves it.
    always_comb begin
        state_d = state_q;
        qcnt_d  = qcnt_q;
        case (state_q)
            BUSY: if (quiet) begin
                qcnt_d  = QW'(1);
                state_d = (IDLE_HOLD == 1) ? IDLE : DRAIN;
            end
            DRAIN: if (quiet) begin
                qcnt_d = qcnt_q + 1'b1;
                if (qcnt_q + 1'b1 == QW'(IDLE_HOLD)) state_d = IDLE;
            end else begin
                qcnt_d  = '0;
                state_d = BUSY;
            end
            IDLE: if (any_pulse) begin
                qcnt_d  = '0;
                state_d = BUSY;
            end
            default: begin
                qcnt_d  = '0;
                state_d = BUSY;
            end
        endcase
    end

    // Halt looks at next-state counts so it moves on the same edge as inflight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) halt <= 1'b0;
        else        halt <= halt_en & (halt_thresh != '0) & (|ch_hit);
    end

    // Sticky interrupt status (set beats clear) and registered aggregate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_stat <= '0;
            int_out  <= 1'b0;
        end else begin
            int_stat <= int_src | (int_stat & ~int_clr);
            int_out  <= (|(int_stat & ~int_mask)) | (|ovf_err) | (|unf_err);
        end
    end
endmodule

// File: tb/tb_cr_cddip_support_mc.sv
// Self-checking bench: reference model, directed table and corner sequences.
module tb_cr_cddip_support_mc;
    localparam int NC = 4, CW = 4, IH = 8, NI = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 0, rst_n = 0;
    logic [NC-1:0] cqe_rx = 0, cqe_exit = 0;
    logic halt_en = 0;
    logic [CW-1:0] halt_thresh = 0;
    logic [NI-1:0] int_src = 0, int_mask = 0, int_clr = 0;
    logic err_clr = 0;
    logic [NC*CW-1:0] inflight;
    logic [NC-1:0] ovf_err, unf_err;
    logic [NI-1:0] int_stat;
    logic int_out, idle, halt;

    int errors = 0, checks = 0;

    // Reference model state
    int mcnt[NC];
    logic [NC-1:0] movf, munf;
    logic [NI-1:0] mist;
    logic miout, mhalt, midle;
    int streak;

    cr_cddip_support_mc #(.N_CH(NC), .CNT_W(CW), .IDLE_HOLD(IH), .N_INT_SRC(NI)) dut (
        .clk(clk), .rst_n(rst_n), .cqe_rx(cqe_rx), .cqe_exit(cqe_exit),
        .halt_en(halt_en), .halt_thresh(halt_thresh), .int_src(int_src),
        .int_mask(int_mask), .int_clr(int_clr), .err_clr(err_clr),
        .inflight(inflight), .ovf_err(ovf_err), .unf_err(unf_err),
        .int_stat(int_stat), .int_out(int_out), .idle(idle), .halt(halt));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int cnt_of(input int c);
        return int'(inflight[c*CW +: CW]);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NC; c++) mcnt[c] = 0;
        movf = 0; munf = 0; mist = 0; miout = 0; mhalt = 0; midle = 0; streak = 0;
    endtask

    // One clock: predict from current inputs, take the edge, compare everything.
    task automatic step();
        int ncnt[NC];
        logic [NC-1:0] so, su;
        logic quiet, hh, io;
        logic [NC*CW-1:0] exp_inf;
        quiet = (cqe_rx == 0) && (cqe_exit == 0);
        so = 0; su = 0; hh = 0;
        for (int c = 0; c < NC; c++) begin
            if (mcnt[c] != 0) quiet = 0;
            ncnt[c] = mcnt[c];
            if (cqe_rx[c] && !cqe_exit[c]) begin
                if (mcnt[c] == CMAX) so[c] = 1; else ncnt[c] = mcnt[c] + 1;
            end else if (cqe_exit[c] && !cqe_rx[c]) begin
                if (mcnt[c] == 0) su[c] = 1; else ncnt[c] = mcnt[c] - 1;
            end
            if (ncnt[c] >= int'(halt_thresh)) hh = 1;
        end
        io = ((mist & ~int_mask) != 0) || (movf != 0) || (munf != 0);
        @(posedge clk); #1;
        for (int c = 0; c < NC; c++) mcnt[c] = ncnt[c];
        movf = so | (err_clr ? '0 : movf);
        munf = su | (err_clr ? '0 : munf);
        mist = int_src | (mist & ~int_clr);
        miout = io;
        mhalt = halt_en && (halt_thresh != 0) && hh;
        streak = quiet ? streak + 1 : 0;
        midle = (streak >= IH);
        exp_inf = 0;
        for (int c = 0; c < NC; c++) exp_inf[c*CW +: CW] = CW'(mcnt[c]);
        chk("inflight", inflight, exp_inf);
        chk("ovf_err", ovf_err, movf);
        chk("unf_err", unf_err, munf);
        chk("int_stat", int_stat, mist);
        chk("int_out", int_out, miout);
        chk("halt", halt, mhalt);
        chk("idle", idle, midle);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_inflight"}, inflight, 0);
        chk({nm, "_errs"}, {ovf_err, unf_err}, 0);
        chk({nm, "_int"}, {int_stat, int_out}, 0);
        chk({nm, "_idle_halt"}, {idle, halt}, 0);
    endtask

    typedef struct {
        logic [NC-1:0] rx, ex;
        logic hen;
        logic [CW-1:0] thr;
        int ch, cnt;
        logic h, idl;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(input logic [NC-1:0] rx, ex, input logic hen,
                                input logic [CW-1:0] thr, input int ch, cnt,
                                input logic h, idl);
        vec_t v;
        v.rx = rx; v.ex = ex; v.hen = hen; v.thr = thr;
        v.ch = ch; v.cnt = cnt; v.h = h; v.idl = idl;
        return v;
    endfunction

    initial begin
        // ch0 ramp up and down, then 8 quiet cycles to idle
        for (int i = 1; i <= 5; i++) tbl.push_back(mk(4'b0001, 0, 0, 0, 0, i, 0, 0));
        for (int i = 4; i >= 0; i--) tbl.push_back(mk(0, 4'b0001, 0, 0, 0, i, 0, 0));
        for (int i = 1; i <= 8; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, i == 8));
        // ch3 halt with threshold 3
        tbl.push_back(mk(4'b1000, 0, 1, 3, 3, 1, 0, 0));
        tbl.push_back(mk(4'b1000, 0, 1, 3, 3, 2, 0, 0));
        tbl.push_back(mk(4'b1000, 0, 1, 3, 3, 3, 1, 0));
        tbl.push_back(mk(0, 4'b1000, 1, 3, 3, 2, 0, 0));
        tbl.push_back(mk(0, 4'b1000, 1, 3, 3, 1, 0, 0));
        tbl.push_back(mk(0, 4'b1000, 1, 3, 3, 0, 0, 0));
        // threshold 0 disables halt
        for (int i = 1; i <= 3; i++) tbl.push_back(mk(4'b1000, 0, 1, 0, 3, i, 0, 0));
        for (int i = 2; i >= 0; i--) tbl.push_back(mk(0, 4'b1000, 1, 0, 3, i, 0, 0));

        // Reset state
        model_reset();
        #23;
        chk_zero("reset");
        rst_n = 1;
        for (int i = 1; i <= IH; i++) begin
            step();
            if (i == IH - 1) chk("idle_before_hold", idle, 0);
        end
        chk("idle_at_hold", idle, 1);

        // Table-driven vectors
        foreach (tbl[i]) begin
            cqe_rx = tbl[i].rx; cqe_exit = tbl[i].ex;
            halt_en = tbl[i].hen; halt_thresh = tbl[i].thr;
            step();
            chk($sformatf("tbl%0d_cnt", i), cnt_of(tbl[i].ch), tbl[i].cnt);
            chk($sformatf("tbl%0d_halt", i), halt, tbl[i].h);
            chk($sformatf("tbl%0d_idle", i), idle, tbl[i].idl);
        end
        cqe_rx = 0; cqe_exit = 0; halt_en = 0; halt_thresh = 0;

        // ch2: simultaneous rx/exit at zero, then lone exit underflow
        cqe_rx = 4'b0100; cqe_exit = 4'b0100;
        repeat (10) step();
        chk("ch2_both_cnt", cnt_of(2), 0);
        chk("ch2_both_unf", unf_err, 0);
        cqe_rx = 0;
        step();
        cqe_exit = 0;
        chk("ch2_unf_set", unf_err, 4'b0100);
        chk("ch2_int_1edge", int_out, 0);
        step();
        chk("ch2_int_2edge", int_out, 1);
        err_clr = 1;
        step();
        err_clr = 0;
        chk("ch2_unf_clr", unf_err, 0);
        step();
        chk("ch2_int_clr", int_out, 0);

        // ch1 saturation at 15, overflow on 16th, set beats err_clr
        cqe_rx = 4'b0010;
        repeat (15) step();
        chk("ch1_sat_cnt", cnt_of(1), CMAX);
        chk("ch1_no_ovf_yet", ovf_err, 0);
        step();
        chk("ch1_sat_hold", cnt_of(1), CMAX);
        chk("ch1_ovf", ovf_err, 4'b0010);
        err_clr = 1;
        step();
        chk("ch1_set_wins", ovf_err, 4'b0010);
        cqe_rx = 0;
        step();
        err_clr = 0;
        chk("ch1_ovf_clr", ovf_err, 0);
        cqe_exit = 4'b0010;
        repeat (15) step();
        cqe_exit = 0;
        chk("ch1_drained", cnt_of(1), 0);

        // Masked interrupt, unmask, set-beats-clear
        int_mask = 8'h20; int_src = 8'h20;
        step();
        int_src = 0;
        chk("int5_stat", int_stat[5], 1);
        step();
        chk("int5_masked", int_out, 0);
        int_mask = 0;
        step();
        chk("int5_unmasked", int_out, 1);
        int_src = 8'h20; int_clr = 8'h20;
        step();
        int_src = 0;
        chk("int5_set_wins", int_stat[5], 1);
        step();
        int_clr = 0;
        chk("int5_cleared", int_stat[5], 0);
        step();
        chk("int5_out_low", int_out, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            cqe_rx = NC'($urandom) & NC'($urandom);
            cqe_exit = NC'($urandom) & NC'($urandom);
            if ($urandom_range(0, 3) == 0) begin cqe_rx = 0; cqe_exit = 0; end
            halt_en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) halt_thresh = CW'($urandom);
            int_src = ($urandom_range(0, 7) == 0) ? NI'($urandom) : '0;
            int_clr = ($urandom_range(0, 3) == 0) ? NI'($urandom) : '0;
            if ($urandom_range(0, 15) == 0) int_mask = NI'($urandom);
            err_clr = ($urandom_range(0, 15) == 0);
            step();
        end

        // Asynchronous reset mid-operation
        cqe_rx = 4'b1111; cqe_exit = 0; int_src = 8'hff; err_clr = 0; int_clr = 0;
        step();
        #2 rst_n = 0;
        #1 chk_zero("async_rst");
        cqe_rx = 0; int_src = 0; halt_en = 0;
        model_reset();
        #1 rst_n = 1;
        repeat (IH + 2) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
